// File: rtl/video_mmcm_drp_ctrl.sv
// rtl/video_mmcm_drp_ctrl.sv - MMCM DRP read-modify-write sequencer with lock wait and video reset ownership
module video_mmcm_drp_ctrl #(
    parameter int MODE_W       = 1,
    parameter int NUM_REGS     = 23,
    parameter int RST_HOLD     = 4,
    parameter int DRP_TIMEOUT  = 64,
    parameter int LOCK_STABLE  = 16,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int BOOT_MODE    = 0,
    localparam int IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              sysclk_i,
    input  logic              rst_i,
    input  logic              cfg_req_i,
    input  logic [MODE_W-1:0] cfg_mode_i,
    output logic              cfg_busy_o,
    output logic              cfg_done_o,
    output logic              cfg_err_o,
    output logic [MODE_W-1:0] tbl_mode_o,
    output logic [IDX_W-1:0]  tbl_idx_o,
    input  logic [6:0]        tbl_daddr_i,
    input  logic [15:0]       tbl_mask_i,
    input  logic [15:0]       tbl_data_i,
    output logic              drp_den_o,
    output logic              drp_dwe_o,
    output logic [6:0]        drp_daddr_o,
    output logic [15:0]       drp_di_o,
    input  logic [15:0]       drp_do_i,
    input  logic              drp_drdy_i,
    output logic              mmcm_rst_o,
    input  logic              mmcm_locked_i,
    output logic              video_rst_o
);

    localparam int CNT_MAX0 = (RST_HOLD > DRP_TIMEOUT) ? RST_HOLD : DRP_TIMEOUT;
    localparam int CNT_MAX  = (CNT_MAX0 > LOCK_TIMEOUT) ? CNT_MAX0 : LOCK_TIMEOUT;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int SW       = $clog2(LOCK_STABLE + 1);

    localparam logic [CW-1:0]    HOLD_LAST = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0]    DRP_LAST  = CW'(DRP_TIMEOUT - 1);
    localparam logic [CW-1:0]    LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0]    STAB_LAST = SW'(LOCK_STABLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REGS - 1);

    typedef enum logic [3:0] {
        IDLE, ASSERT_RST, READ, WAIT_RD, WRITE, WAIT_WR, RELEASE, WAIT_LOCK, DONE, ERR
    } state_t;

    state_t            state_q, state_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              boot_pend_q, boot_pend_d;
    logic              err_q, err_d;
    logic              mmcm_rst_q, mmcm_rst_d;
    logic              video_rst_q, video_rst_d;
    logic [15:0]       rd_q, rd_d;
    logic [6:0]        daddr_q, daddr_d;
    logic [15:0]       di_q, di_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     stab_q, stab_d;
    logic              lock_meta_q, lock_sync_q;
    logic [15:0]       rmw;
    logic              go_err;

    assign rmw = (rd_q & tbl_mask_i) | (tbl_data_i & ~tbl_mask_i);

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mode_q      <= MODE_W'(BOOT_MODE);
            idx_q       <= '0;
            boot_pend_q <= 1'b1;
            err_q       <= 1'b0;
            mmcm_rst_q  <= 1'b1;
            video_rst_q <= 1'b1;
            rd_q        <= '0;
            daddr_q     <= '0;
            di_q        <= '0;
            cnt_q       <= '0;
            stab_q      <= '0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            idx_q       <= idx_d;
            boot_pend_q <= boot_pend_d;
            err_q       <= err_d;
            mmcm_rst_q  <= mmcm_rst_d;
            video_rst_q <= video_rst_d;
            rd_q        <= rd_d;
            daddr_q     <= daddr_d;
            di_q        <= di_d;
            cnt_q       <= cnt_d;
            stab_q      <= stab_d;
            lock_meta_q <= mmcm_locked_i;
            lock_sync_q <= lock_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        idx_d       = idx_q;
        boot_pend_d = boot_pend_q;
        err_d       = err_q;
        mmcm_rst_d  = mmcm_rst_q;
        video_rst_d = video_rst_q;
        rd_d        = rd_q;
        daddr_d     = daddr_q;
        di_d        = di_q;
        cnt_d       = cnt_q;
        stab_d      = stab_q;
        go_err      = 1'b0;

        case (state_q)
            IDLE: begin
                if (boot_pend_q || cfg_req_i) begin
                    mode_d      = boot_pend_q ? MODE_W'(BOOT_MODE) : cfg_mode_i;
                    boot_pend_d = 1'b0;
                    err_d       = 1'b0;
                    mmcm_rst_d  = 1'b1;
                    video_rst_d = 1'b1;
                    idx_d       = '0;
                    cnt_d       = '0;
                    state_d     = ASSERT_RST;
                end else if (!lock_sync_q) begin
                    // Lost lock after a good config: hold the video domain until reconfigured.
                    video_rst_d = 1'b1;
                end
            end
            ASSERT_RST: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = READ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READ: begin
                daddr_d = tbl_daddr_i;
                cnt_d   = '0;
                state_d = WAIT_RD;
            end
            WAIT_RD: begin
                if (drp_drdy_i) begin
                    rd_d    = drp_do_i;
                    state_d = WRITE;
                end else if (cnt_q == DRP_LAST) begin
                    go_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE: begin
                di_d    = rmw;
                cnt_d   = '0;
                state_d = WAIT_WR;
            end
            WAIT_WR: begin
                if (drp_drdy_i) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = RELEASE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = READ;
                    end
                end else if (cnt_q == DRP_LAST) begin
                    go_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                mmcm_rst_d = 1'b0;
                cnt_d      = '0;
                stab_d     = '0;
                state_d    = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                stab_d = lock_sync_q ? stab_q + 1'b1 : '0;
                if (lock_sync_q && stab_q == STAB_LAST) begin
                    video_rst_d = 1'b0;
                    state_d     = DONE;
                end else if (cnt_q == LOCK_LAST) begin
                    go_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Error is flagged on entry so cfg_err and the reset gating line up with the ERR cycle.
        if (go_err) begin
            err_d       = 1'b1;
            mmcm_rst_d  = 1'b1;
            video_rst_d = 1'b1;
            state_d     = ERR;
        end
    end

    assign cfg_busy_o  = !(state_q inside {IDLE, DONE, ERR});
    assign cfg_done_o  = (state_q == DONE);
    assign cfg_err_o   = err_q;
    assign tbl_mode_o  = mode_q;
    assign tbl_idx_o   = idx_q;
    assign drp_den_o   = (state_q == READ) || (state_q == WRITE);
    assign drp_dwe_o   = (state_q == WRITE);
    assign drp_daddr_o = (state_q == READ) ? tbl_daddr_i : daddr_q;
    assign drp_di_o    = (state_q == WRITE) ? rmw : di_q;
    assign mmcm_rst_o  = mmcm_rst_q;
    assign video_rst_o = video_rst_q;

endmodule

// File: tb/tb_video_mmcm_drp_ctrl.sv
// tb/tb_video_mmcm_drp_ctrl.sv - scoreboard bench for video_mmcm_drp_ctrl with DRP, ROM and lock models
module tb_video_mmcm_drp_ctrl;

    localparam int NREG = 2;
    localparam int DTO  = 16;
    localparam int LST  = 16;
    localparam int LTO  = 200;
    localparam int HOLD = 4;

    localparam int K_RD = 0, K_WR = 1, K_DONE = 2, K_ERR = 3;

    logic        sysclk_i = 1'b0;
    logic        rst_i;
    logic        cfg_req_i;
    logic [0:0]  cfg_mode_i;
    logic        cfg_busy_o, cfg_done_o, cfg_err_o;
    logic [0:0]  tbl_mode_o;
    logic [0:0]  tbl_idx_o;
    logic [6:0]  tbl_daddr_i;
    logic [15:0] tbl_mask_i, tbl_data_i;
    logic        drp_den_o, drp_dwe_o;
    logic [6:0]  drp_daddr_o;
    logic [15:0] drp_di_o;
    logic [15:0] drp_do_i = 16'h0;
    logic        drp_drdy_i = 1'b0;
    logic        mmcm_rst_o;
    logic        mmcm_locked_i = 1'b0;
    logic        video_rst_o;

    video_mmcm_drp_ctrl #(
        .MODE_W(1), .NUM_REGS(NREG), .RST_HOLD(HOLD), .DRP_TIMEOUT(DTO),
        .LOCK_STABLE(LST), .LOCK_TIMEOUT(LTO), .BOOT_MODE(0)
    ) dut (
        .sysclk_i(sysclk_i), .rst_i(rst_i), .cfg_req_i(cfg_req_i), .cfg_mode_i(cfg_mode_i),
        .cfg_busy_o(cfg_busy_o), .cfg_done_o(cfg_done_o), .cfg_err_o(cfg_err_o),
        .tbl_mode_o(tbl_mode_o), .tbl_idx_o(tbl_idx_o), .tbl_daddr_i(tbl_daddr_i),
        .tbl_mask_i(tbl_mask_i), .tbl_data_i(tbl_data_i), .drp_den_o(drp_den_o),
        .drp_dwe_o(drp_dwe_o), .drp_daddr_o(drp_daddr_o), .drp_di_o(drp_di_o),
        .drp_do_i(drp_do_i), .drp_drdy_i(drp_drdy_i), .mmcm_rst_o(mmcm_rst_o),
        .mmcm_locked_i(mmcm_locked_i), .video_rst_o(video_rst_o)
    );

    always #4 sysclk_i = ~sysclk_i;

    int cyc = 0;
    always @(posedge sysclk_i) cyc <= cyc + 1;

    // Register table: page = mode, entries at 0x10 + 8*mode + idx
    always_comb begin
        tbl_daddr_i = 7'(16 + 8 * int'(tbl_mode_o) + int'(tbl_idx_o));
        case ({tbl_mode_o, tbl_idx_o})
            2'b00:   begin tbl_mask_i = 16'hFF00; tbl_data_i = 16'h1234; end
            2'b01:   begin tbl_mask_i = 16'h0F0F; tbl_data_i = 16'hA0A0; end
            2'b10:   begin tbl_mask_i = 16'h00FF; tbl_data_i = 16'hFFFF; end
            default: begin tbl_mask_i = 16'hF000; tbl_data_i = 16'h0000; end
        endcase
    end

    int   drop_read   = 0;
    bit   lock_toggle = 1'b0;

    logic [15:0] mem [0:127];
    bit          mem_init = 1'b0;
    int          m_cnt = 0, rd_num = 0;
    logic [6:0]  m_addr;
    logic        m_we, m_drop;
    logic [15:0] m_wd;

    // DRP slave: drdy follows den by two cycles; a selected read can be swallowed.
    always @(posedge sysclk_i) begin
        if (!mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] = 16'h0;
            mem[7'h10] = 16'hABCD;
            mem[7'h11] = 16'h5555;
            mem[7'h18] = 16'h0000;
            mem[7'h19] = 16'hFFFF;
            mem_init = 1'b1;
        end
        drp_drdy_i <= 1'b0;
        if (!cfg_busy_o) rd_num = 0;
        if (rst_i) begin
            m_cnt = 0;
        end else begin
            if (m_cnt != 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0 && !m_drop) begin
                    drp_drdy_i <= 1'b1;
                    drp_do_i   <= mem[m_addr];
                    if (m_we) mem[m_addr] = m_wd;
                end
            end
            if (drp_den_o) begin
                m_cnt  = 2;
                m_addr = drp_daddr_o;
                m_we   = drp_dwe_o;
                m_wd   = drp_di_o;
                if (!drp_dwe_o) rd_num = rd_num + 1;
                m_drop = !drp_dwe_o && (rd_num == drop_read);
            end
        end
    end

    int lcnt = 0;
    always @(posedge sysclk_i) begin
        if (mmcm_rst_o) begin
            lcnt = 0;
            mmcm_locked_i <= 1'b0;
        end else begin
            lcnt = lcnt + 1;
            mmcm_locked_i <= lock_toggle ? lcnt[3] : (lcnt >= 10);
        end
    end

    typedef struct {
        int         kind;
        logic [6:0] addr;
        logic [15:0] data;
        bit         chk_to;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push(int kind, logic [6:0] addr, logic [15:0] data, bit chk_to);
        exp_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.chk_to = chk_to;
        sbq.push_back(e);
    endfunction

    int  last_rd = 0;
    bit  err_prev = 1'b0;

    function automatic void pop_check(int kind, logic [6:0] addr, logic [15:0] data);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d addr 0x%0h, expected none (cycle %0d)",
                     kind, addr, cyc);
            return;
        end
        e = sbq.pop_front();
        chk("event_kind", 32'(kind), 32'(e.kind));
        if (e.kind == K_RD || e.kind == K_WR) chk("drp_daddr", 32'(addr), 32'(e.addr));
        if (e.kind == K_WR) chk("drp_di", 32'(data), 32'(e.data));
        if (e.kind == K_ERR) begin
            chk("err_mmcm_rst", 32'(mmcm_rst_o), 32'd1);
            chk("err_busy", 32'(cfg_busy_o), 32'd0);
            chk("err_video_rst", 32'(video_rst_o), 32'd1);
            if (e.chk_to) chk("drp_timeout_cycles", 32'(cyc - last_rd), 32'(DTO + 1));
        end
        if (e.kind == K_DONE) chk("done_video_rst", 32'(video_rst_o), 32'd0);
    endfunction

    always @(negedge sysclk_i) begin
        if (!rst_i) begin
            if (drp_den_o) begin
                if (!drp_dwe_o) last_rd = cyc;
                pop_check(drp_dwe_o ? K_WR : K_RD, drp_daddr_o, drp_di_o);
            end
            if (cfg_done_o) pop_check(K_DONE, 7'h0, 16'h0);
            if (cfg_err_o && !err_prev) pop_check(K_ERR, 7'h0, 16'h0);
        end
        err_prev = cfg_err_o;
    end

    task automatic check_reset_vals(string tag);
        chk({tag, "_busy"}, 32'(cfg_busy_o), 32'd0);
        chk({tag, "_done"}, 32'(cfg_done_o), 32'd0);
        chk({tag, "_err"}, 32'(cfg_err_o), 32'd0);
        chk({tag, "_den"}, 32'(drp_den_o), 32'd0);
        chk({tag, "_dwe"}, 32'(drp_dwe_o), 32'd0);
        chk({tag, "_daddr"}, 32'(drp_daddr_o), 32'd0);
        chk({tag, "_di"}, 32'(drp_di_o), 32'd0);
        chk({tag, "_idx"}, 32'(tbl_idx_o), 32'd0);
        chk({tag, "_mode"}, 32'(tbl_mode_o), 32'd0);
        chk({tag, "_mmcm_rst"}, 32'(mmcm_rst_o), 32'd1);
        chk({tag, "_video_rst"}, 32'(video_rst_o), 32'd1);
    endtask

    task automatic wait_seq(string tag);
        int n = 0;
        while (!cfg_busy_o && n < 20) begin @(negedge sysclk_i); n++; end
        if (!cfg_busy_o) chk({tag, "_busy_rise_timeout"}, 32'(cfg_busy_o), 32'd1);
        n = 0;
        while (cfg_busy_o && n < 2000) begin @(negedge sysclk_i); n++; end
        if (cfg_busy_o) chk({tag, "_busy_fall_timeout"}, 32'(cfg_busy_o), 32'd0);
        repeat (4) @(negedge sysclk_i);
    endtask

    task automatic request(logic [0:0] mode);
        cfg_mode_i = mode;
        cfg_req_i  = 1'b1;
        @(negedge sysclk_i);
        cfg_req_i  = 1'b0;
    endtask

    task automatic push_mode0_ok();
        push(K_RD, 7'h10, 16'h0, 0);
        push(K_WR, 7'h10, 16'hAB34, 0);
        push(K_RD, 7'h11, 16'h0, 0);
        push(K_WR, 7'h11, 16'hA5A5, 0);
    endtask

    initial begin
        int n;
        rst_i      = 1'b1;
        cfg_req_i  = 1'b0;
        cfg_mode_i = 1'b0;
        repeat (3) @(negedge sysclk_i);
        check_reset_vals("reset");

        // Boot config of mode 0, including RMW 0xABCD/0xFF00/0x1234 -> 0xAB34
        push_mode0_ok();
        push(K_DONE, 7'h0, 16'h0, 0);
        rst_i = 1'b0;
        wait_seq("boot");
        chk("boot_err", 32'(cfg_err_o), 32'd0);
        chk("boot_video_rst", 32'(video_rst_o), 32'd0);

        // Mode 1 with a second request mid-sequence that must be ignored
        push(K_RD, 7'h18, 16'h0, 0);
        push(K_WR, 7'h18, 16'hFF00, 0);
        push(K_RD, 7'h19, 16'h0, 0);
        push(K_WR, 7'h19, 16'hF000, 0);
        push(K_DONE, 7'h0, 16'h0, 0);
        request(1'b1);
        repeat (10) @(negedge sysclk_i);
        request(1'b0);
        @(negedge sysclk_i);
        chk("mode1_latched", 32'(tbl_mode_o), 32'd1);
        wait_seq("mode1");

        // Second read never completes
        drop_read = 2;
        push(K_RD, 7'h10, 16'h0, 0);
        push(K_WR, 7'h10, 16'hAB34, 0);
        push(K_RD, 7'h11, 16'h0, 0);
        push(K_ERR, 7'h0, 16'h0, 1);
        request(1'b0);
        wait_seq("drp_to");
        chk("drp_to_err_sticky", 32'(cfg_err_o), 32'd1);
        drop_read = 0;

        // Lock toggling every 8 cycles never becomes stable
        lock_toggle = 1'b1;
        push_mode0_ok();
        push(K_ERR, 7'h0, 16'h0, 0);
        request(1'b0);
        wait_seq("lock_to");
        chk("lock_to_err_sticky", 32'(cfg_err_o), 32'd1);
        lock_toggle = 1'b0;

        // Reset while waiting for read data, then boot reruns
        push(K_RD, 7'h18, 16'h0, 0);
        request(1'b1);
        n = 0;
        while (!(drp_den_o && !drp_dwe_o) && n < 50) begin @(negedge sysclk_i); n++; end
        chk("abort_read_seen", 32'(drp_den_o && !drp_dwe_o), 32'd1);
        @(negedge sysclk_i);
        rst_i = 1'b1;
        @(negedge sysclk_i);
        check_reset_vals("abort");
        chk("abort_queue_empty", 32'(sbq.size()), 32'd0);
        push_mode0_ok();
        push(K_DONE, 7'h0, 16'h0, 0);
        @(negedge sysclk_i);
        rst_i = 1'b0;
        wait_seq("reboot");
        chk("reboot_video_rst", 32'(video_rst_o), 32'd0);

        chk("final_queue_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
